// File: rtl/oam_dma_ctl.sv
// Sprite DMA sequencer: stalls the CPU and copies one 256-byte page to the OAM data port.
// Optional build macro OAM_DMA_DUMMY_CYCLE_EN inserts one alignment cycle before the first read.
module oam_dma_ctl #(
    parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
    parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_addr_in,
    input  logic [7:0]  cpu_dout_in,
    input  logic        cpu_wr_in,
    output logic        cpu_rdy_out,
    output logic [15:0] mem_addr_out,
    output logic [7:0]  mem_dout_out,
    output logic        mem_wr_out,
    input  logic [7:0]  mem_din_in,
    output logic        busy_out
);

`ifdef OAM_DMA_DUMMY_CYCLE_EN
    typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_WRITE, ST_DUMMY} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_WRITE} state_t;
`endif

    state_t     state_q, state_d;
    logic [7:0] page_q, page_d;
    logic [7:0] cnt_q, cnt_d;
    logic       busy_q, busy_d;
    logic       rdy_q, rdy_d;

    logic trigger;
    assign trigger = cpu_wr_in && (cpu_addr_in == DMA_REG_ADDR);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            page_q  <= 8'h00;
            cnt_q   <= 8'h00;
            busy_q  <= 1'b0;
            rdy_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            page_q  <= page_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            rdy_q   <= rdy_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        page_d       = page_q;
        cnt_d        = cnt_q;
        mem_addr_out = {page_q, cnt_q};
        mem_dout_out = 8'h00;
        mem_wr_out   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // The trigger write itself still reaches memory.
                mem_addr_out = cpu_addr_in;
                mem_dout_out = cpu_dout_in;
                mem_wr_out   = cpu_wr_in;
                if (trigger) begin
                    page_d = cpu_dout_in;
                    cnt_d  = 8'h00;
`ifdef OAM_DMA_DUMMY_CYCLE_EN
                    state_d = ST_DUMMY;
`else
                    state_d = ST_READ;
`endif
                end
            end
`ifdef OAM_DMA_DUMMY_CYCLE_EN
            ST_DUMMY: begin
                mem_addr_out = {page_q, 8'h00};
                state_d      = ST_READ;
            end
`endif
            ST_READ: begin
                mem_addr_out = {page_q, cnt_q};
                state_d      = ST_WRITE;
            end
            ST_WRITE: begin
                // mem_din_in holds the byte addressed during the preceding READ.
                mem_addr_out = OAM_DATA_ADDR;
                mem_dout_out = mem_din_in;
                mem_wr_out   = 1'b1;
                if (cnt_q == 8'hFF) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d   = cnt_q + 8'h01;
                    state_d = ST_READ;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
        rdy_d  = ~busy_d;
    end

    assign busy_out    = busy_q;
    assign cpu_rdy_out = rdy_q;

endmodule

// File: tb/tb_oam_dma_ctl.sv
// Directed bench for oam_dma_ctl with a behavioural sync RAM and a scoreboard of expected OAM writes.
module tb_oam_dma_ctl;

`ifdef OAM_DMA_DUMMY_CYCLE_EN
    localparam int STALL = 513;
`else
    localparam int STALL = 512;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cpu_addr_in;
    logic [7:0]  cpu_dout_in;
    logic        cpu_wr_in;
    logic        cpu_rdy_out;
    logic [15:0] mem_addr_out;
    logic [7:0]  mem_dout_out;
    logic        mem_wr_out;
    logic [7:0]  mem_din_in;
    logic        busy_out;

    oam_dma_ctl dut (
        .clk          (clk),
        .rst          (rst),
        .cpu_addr_in  (cpu_addr_in),
        .cpu_dout_in  (cpu_dout_in),
        .cpu_wr_in    (cpu_wr_in),
        .cpu_rdy_out  (cpu_rdy_out),
        .mem_addr_out (mem_addr_out),
        .mem_dout_out (mem_dout_out),
        .mem_wr_out   (mem_wr_out),
        .mem_din_in   (mem_din_in),
        .busy_out     (busy_out)
    );

    always #5 clk = ~clk;

    // Unwritten locations read back a fixed pattern; page 8'h02 gives (i ^ 8'h5A).
    function automatic logic [7:0] init_val(input logic [15:0] a);
        return a[7:0] ^ 8'h5A ^ a[15:8] ^ 8'h02;
    endfunction

    logic [7:0] ram [0:65535];
    logic       written [0:65535];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 65536; i++) written[i] <= 1'b0;
        end else if (mem_wr_out) begin
            ram[mem_addr_out]     <= mem_dout_out;
            written[mem_addr_out] <= 1'b1;
        end
        mem_din_in <= (!rst && written[mem_addr_out]) ? ram[mem_addr_out] : init_val(mem_addr_out);
    end

    typedef struct packed {
        logic [15:0] src;
        logic [7:0]  data;
    } exp_t;

    exp_t        exp_q[$];
    int          errors = 0;
    int          checks = 0;
    int          stall_cnt;
    int          wr_cnt;
    int          oam_total = 0;
    int          forbidden_rd;
    logic [15:0] last_rd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock; observe outputs 1 time unit after the edge and score any DMA traffic.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (mem_wr_out && mem_addr_out == 16'h2004) oam_total++;
        if (busy_out) begin
            stall_cnt++;
            chk("rdy_not_busy", cpu_rdy_out, 1'b0);
            if (!mem_wr_out) begin
                last_rd = mem_addr_out;
                if (mem_addr_out == 16'h0000 || mem_addr_out == 16'h0100) forbidden_rd++;
            end else begin
                wr_cnt++;
                chk("wr_addr", mem_addr_out, 16'h2004);
                if (exp_q.size() == 0) begin
                    chk("unexpected_wr", 1'b1, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_data", mem_dout_out, e.data);
                    chk("wr_src", last_rd, e.src);
                end
            end
        end
    endtask

    task automatic cpu_drive(input logic [15:0] a, input logic [7:0] d, input logic w);
        cpu_addr_in = a;
        cpu_dout_in = d;
        cpu_wr_in   = w;
    endtask

    // Issue the trigger write and queue the 256 expected OAM writes.
    task automatic start_dma(input logic [7:0] page);
        cpu_drive(16'h4014, page, 1'b1);
        #1;
        chk("trig_pass_addr", mem_addr_out, 16'h4014);
        chk("trig_pass_wr", mem_wr_out, 1'b1);
        for (int i = 0; i < 256; i++) begin
            exp_t e;
            e.src  = {page, i[7:0]};
            e.data = init_val({page, i[7:0]});
            exp_q.push_back(e);
        end
        stall_cnt    = 0;
        wr_cnt       = 0;
        forbidden_rd = 0;
        last_rd      = 16'hxxxx;
        tick();
        cpu_drive(16'h0000, 8'h00, 1'b0);
        chk("first_busy", busy_out, 1'b1);
        chk("first_no_wr", mem_wr_out, 1'b0);
        chk("first_addr", mem_addr_out, {page, 8'h00});
    endtask

    task automatic finish_dma(input logic noisy, input logic [15:0] last_src);
        int guard = 0;
        while (busy_out && guard < 2000) begin
            if (noisy) cpu_drive(16'h4014, 8'h77, 1'b1);
            else       cpu_drive(16'h0000, 8'h00, 1'b0);
            tick();
            guard++;
        end
        cpu_drive(16'h0000, 8'h00, 1'b0);
        chk("done_in_budget", (guard < 2000), 1'b1);
        chk("stall_len", stall_cnt, STALL);
        chk("wr_count", wr_cnt, 256);
        chk("queue_empty", exp_q.size(), 0);
        chk("last_src", last_rd, last_src);
        chk("rdy_after", cpu_rdy_out, 1'b1);
        $display("dma page=%02h stall=%0d writes=%0d", last_src[15:8], stall_cnt, wr_cnt);
    endtask

    initial begin
        int total_before;
        rst = 1'b1;
        cpu_drive(16'h0000, 8'h00, 1'b0);
        repeat (3) tick();
        rst = 1'b0;
        #1;
        chk("rst_busy", busy_out, 1'b0);
        chk("rst_rdy", cpu_rdy_out, 1'b1);
        chk("rst_pass", mem_addr_out, 16'h0000);
        $display("reset released busy=%0b rdy=%0b", busy_out, cpu_rdy_out);

        // Full copy from page 02.
        start_dma(8'h02);
        finish_dma(1'b0, 16'h02FF);

        // Reset on the 100th write, then a full copy from page 03.
        start_dma(8'h02);
        for (int g = 0; g < 1000 && wr_cnt < 100; g++) tick();
        chk("reached_wr100", wr_cnt, 100);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_busy", busy_out, 1'b0);
        chk("mid_rst_rdy", cpu_rdy_out, 1'b1);
        exp_q.delete();
        total_before = oam_total;
        cpu_drive(16'h0456, 8'h3C, 1'b0);
        #1;
        chk("mid_rst_pass", mem_addr_out, 16'h0456);
        repeat (20) tick();
        cpu_drive(16'h0000, 8'h00, 1'b0);
        chk("no_more_oam", oam_total, total_before);
        $display("reset mid-transfer oam_writes_after=%0d", oam_total - total_before);
        start_dma(8'h03);
        finish_dma(1'b0, 16'h03FF);

        // Reset coinciding with a trigger wins.
        rst = 1'b1;
        cpu_drive(16'h4014, 8'h05, 1'b1);
        tick();
        rst = 1'b0;
        cpu_drive(16'h0000, 8'h00, 1'b0);
        tick();
        chk("rst_vs_trig", busy_out, 1'b0);
        $display("rst with trigger busy=%0b", busy_out);

        // Idle passthrough write then read.
        cpu_drive(16'h0123, 8'hA7, 1'b1);
        #1;
        chk("pt_wr_addr", mem_addr_out, 16'h0123);
        chk("pt_wr_data", mem_dout_out, 8'hA7);
        chk("pt_wr_en", mem_wr_out, 1'b1);
        tick();
        cpu_drive(16'h0123, 8'h00, 1'b0);
        #1;
        chk("pt_rd_addr", mem_addr_out, 16'h0123);
        chk("pt_rd_en", mem_wr_out, 1'b0);
        tick();
        chk("pt_rd_data", mem_din_in, 8'hA7);
        chk("pt_rdy", cpu_rdy_out, 1'b1);
        $display("passthrough read 0123 -> %02h", mem_din_in);

        // Near-miss addresses must not trigger.
        cpu_drive(16'h4015, 8'h02, 1'b1);
        tick();
        cpu_drive(16'h2014, 8'h02, 1'b1);
        tick();
        cpu_drive(16'h0000, 8'h00, 1'b0);
        tick();
        chk("no_trig_busy", busy_out, 1'b0);
        chk("no_trig_rdy", cpu_rdy_out, 1'b1);
        $display("near-miss writes busy=%0b", busy_out);

        // Retrigger attempts while busy are ignored.
        start_dma(8'h02);
        finish_dma(1'b1, 16'h02FF);

        // Top page ends at FFFF without wrapping.
        start_dma(8'hFF);
        finish_dma(1'b0, 16'hFFFF);
        chk("no_wrap_reads", forbidden_rd, 0);
        tick();
        chk("idle_after_ff", busy_out, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
